// File: rtl/seq_mult_32.sv
// Sequential unsigned 32x32 -> 64-bit shift-add multiplier, one multiplier bit per clock.
// Each partial sum comes from a 32-bit carry-lookahead adder; product is handed off via start/done.

module CLA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        of
);
  logic [31:0] p;
  logic [31:0] g;
  logic [32:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Eight 4-bit lookahead groups; group carries chain between groups.
  always_comb begin
    c = '0;
    c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];
  assign of   = c[32] ^ c[31];
endmodule

module seq_mult_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               cla_of_unused;
  logic [2*WIDTH-1:0] shifted;
  logic               accept;
  logic               last;

  // Handshake: start is only honoured outside RUN; operands are captured on that same edge.
  assign accept = start && (state_q != RUN);
  assign last   = (state_q == RUN) && (cnt == CNT_W'(WIDTH-1));

  assign add_b   = acc_lo[0] ? mcand : '0;
  assign shifted = {cout, sum, acc_lo[WIDTH-1:1]};

  CLA_32bit u_cla (
    .a    (acc_hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout),
    .of   (cla_of_unused)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt     <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      product <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mcand  <= a;
        acc_lo <= b;
        acc_hi <= '0;
        cnt    <= '0;
      end else if (state_q == RUN) begin
        {acc_hi, acc_lo} <= shifted;
        cnt              <= cnt + CNT_W'(1);
        if (last) product <= shifted;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_seq_mult_32.sv
// Directed-vector bench for seq_mult_32: table of operand/product records plus
// hand-written sequences for start-during-run, mid-run reset and back-to-back starts.

module tb_seq_mult_32;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int total;
  int bad;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic [63:0] exp_q[$];

  seq_mult_32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue start at a negedge; returns after the accept edge, at the following negedge.
  task automatic drive_start(input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait the remaining 31 edges after acceptance, checking no early done, then the completion.
  task automatic finish_mult(input string name);
    logic [63:0] exp;
    int early;
    early = 0;
    for (int i = 1; i < 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b1) early++;
    end
    chk({name, "_run"}, 64'(early), 64'd0);
    @(posedge clk);
    @(negedge clk);
    exp = exp_q.pop_front();
    chk({name, "_done"}, {63'd0, done}, 64'd1);
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
    chk({name, "_prod"}, product, exp);
  endtask

  task automatic run_mult(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp);
    exp_q.push_back(exp);
    drive_start(av, bv);
    finish_mult(name);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int pulses;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,          32'h1234_5678,  64'h0};
    vecs[3] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
    vecs[4] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
    vecs[6] = '{32'd7,          32'd9,          64'h0000_0000_0000_003F};
    vecs[7] = '{32'hDEAD_BEEF,  32'd0,          64'h0};
    vecs[8] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
    vecs[9] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};

    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_prod", product, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
      @(negedge clk);
      chk($sformatf("vec%0d_idle", i), {62'd0, busy, done}, 64'd0);
      chk($sformatf("vec%0d_hold", i), product, vecs[i].exp);
    end

    // start pulsed with new operands at RUN cycle 10 must be ignored
    drive_start(32'd3, 32'd5);
    pulses = 0;
    for (int i = 1; i <= 32; i++) begin
      if (i == 10) begin
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd9;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) pulses++;
      if (i == 32) chk("ign_prod", product, 64'h0000_0000_0000_000F);
    end
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("ign_pulses", 64'(pulses), 64'd1);

    // reset asserted at RUN cycle 16 aborts the multiply
    drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_prod", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {62'd0, busy, done}, 64'd0);
    run_mult("after_rst", 32'd6, 32'd7, 64'd42);

    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    run_mult("b2b_first", 32'd3, 32'd5, 64'd15);
    exp_q.push_back(64'd63);
    drive_start(32'd7, 32'd9);
    chk("b2b_accept_busy", {62'd0, busy, done}, 64'd2);
    chk("b2b_hold", product, 64'd15);
    finish_mult("b2b_second");

    // random pairs against a 64-bit model
    for (int i = 0; i < 150; i++) begin
      ra = $urandom();
      rb = $urandom();
      if (i % 8 == 0) ra = 32'(ra >> $urandom_range(0, 31));
      run_mult($sformatf("rnd%0d", i), ra, rb, {32'b0, ra} * {32'b0, rb});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
